// File: rtl/modexp_engine.sv
// Handshaked bit-serial modular exponentiator: result = base^exp_in mod prime.
// Optional base pre-reduction state enabled by defining MODEXP_BASE_REDUCE_EN.
module modexp_engine #(
  parameter int unsigned WIDTH     = 100,
  parameter int unsigned EXP_WIDTH = WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0]     prime,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 error
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntTop = CW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StReduce, StScan, StMul, StFinish} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     b_q, b_d, p_q, p_d, r_q, r_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [AW-1:0]        acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 error_q, error_d;
  logic [AW-1:0]        p_ext, mul_a, mul_b;

  // One interleaved step: double, reduce, optionally add multiplicand, reduce.
  function automatic logic [AW-1:0] mod_mac(input logic [AW-1:0] acc,
                                            input logic [AW-1:0] mc,
                                            input logic          bit_i,
                                            input logic [AW-1:0] m);
    logic [AW-1:0] t;
    t = acc << 1;
    if (t >= m) t = t - m;
    if (bit_i) begin
      t = t + mc;
      if (t >= m) t = t - m;
    end
    return t;
  endfunction

  assign p_ext = {2'b00, p_q};
  assign mul_a = mod_mac(acc_a_q, {2'b00, b_q}, r_q[cnt_q], p_ext);
  assign mul_b = mod_mac(acc_b_q, {2'b00, b_q}, b_q[cnt_q], p_ext);

`ifdef MODEXP_BASE_REDUCE_EN
  logic [AW-1:0] red_val;
  always_comb begin
    red_val = {acc_a_q[AW-2:0], b_q[cnt_q]};
    if (red_val >= p_ext) red_val = red_val - p_ext;
  end
`endif

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    e_d      = e_q;
    p_d      = p_q;
    r_d      = r_q;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          b_d     = base;
          e_d     = exp_in;
          p_d     = prime;
          r_d     = (prime == WIDTH'(1)) ? '0 : WIDTH'(1);
          acc_a_d = '0;
          acc_b_d = '0;
`ifdef MODEXP_BASE_REDUCE_EN
          if (prime != '0) begin
            state_d = StReduce;
            cnt_d   = CntTop;
          end else begin
            state_d = StScan;
          end
`else
          state_d = StScan;
`endif
        end
      end
      StReduce: begin
`ifdef MODEXP_BASE_REDUCE_EN
        acc_a_d = red_val;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          b_d     = red_val[WIDTH-1:0];
          acc_a_d = '0;
          state_d = StScan;
        end
`else
        state_d = StIdle;
`endif
      end
      StScan: begin
        acc_a_d = '0;
        acc_b_d = '0;
        if (p_q == '0) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = StFinish;
        end
`ifndef MODEXP_BASE_REDUCE_EN
        else if (b_q >= p_q) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = StFinish;
        end
`endif
        else if (e_q == '0) begin
          result_d = r_q;
          error_d  = 1'b0;
          state_d  = StFinish;
        end else begin
          cnt_d   = CntTop;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_a_d = mul_a;
        acc_b_d = mul_b;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          if (e_q[0]) r_d = mul_a[WIDTH-1:0];
          b_d     = mul_b[WIDTH-1:0];
          e_d     = e_q >> 1;
          state_d = StScan;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      b_q      <= '0;
      e_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      e_q      <= e_d;
      p_q      <= p_d;
      r_q      <= r_d;
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign busy   = (state_q == StReduce) || (state_q == StScan) || (state_q == StMul);
  assign done   = (state_q == StFinish);
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_modexp_engine.sv
// Bench for modexp_engine: per-cycle compare against a wide-arithmetic model,
// plus directed runs with hand-computed results and latencies.
module tb_modexp_engine;

  localparam int W  = 100;
  localparam int EW = W + 1;
`ifdef MODEXP_BASE_REDUCE_EN
  localparam int Red = W;
`else
  localparam int Red = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exp_in = '0;
  logic [W-1:0]  prime = '0;
  logic          busy, done, error;
  logic [W-1:0]  result;

  int n_vec = 0;
  int n_err = 0;

  modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .exp_in (exp_in),
    .prime  (prime),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Square-and-multiply with plain wide arithmetic; latency from exponent bit length.
  task automatic model(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] p,
                       output logic [W-1:0] res, output logic err, output int lat);
    logic [2*W-1:0] r, bb, pw;
    logic [EW-1:0]  ee;
    int             len;
    pw  = {{W{1'b0}}, p};
    res = '0;
    err = 1'b1;
    lat = 1;
    if (p == '0) return;
`ifndef MODEXP_BASE_REDUCE_EN
    if (b >= p) return;
`endif
    bb  = {{W{1'b0}}, b} % pw;
    r   = (p == W'(1)) ? '0 : 1;
    ee  = e;
    len = 0;
    while (ee != '0) begin
      if (ee[0]) r = (r * bb) % pw;
      bb = (bb * bb) % pw;
      ee = ee >> 1;
      len++;
    end
    res = r[W-1:0];
    err = 1'b0;
    lat = 1 + Red + len * (W + 1);
  endtask

  // Compare process: tracks acceptance and expected done cycle each negedge.
  logic         m_act = 1'b0;
  int           m_k = 0;
  int           m_lat = 0;
  logic [W-1:0] m_res = '0, held_res = '0;
  logic         m_err = 1'b0, held_err = 1'b0;

  always @(negedge clk) begin
    logic fin;
    fin = 1'b0;
    if (!rst_n) begin
      m_act    = 1'b0;
      held_res = '0;
      held_err = 1'b0;
    end else begin
      if (m_act) begin
        chk("busy", 128'(busy), 128'(m_k < m_lat));
        chk("done", 128'(done), 128'(m_k == m_lat));
        if (m_k == m_lat) begin
          chk("result", 128'(result), 128'(m_res));
          chk("error", 128'(error), 128'(m_err));
          held_res = m_res;
          held_err = m_err;
          m_act    = 1'b0;
          fin      = 1'b1;
        end else begin
          m_k++;
        end
      end else begin
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_done", 128'(done), 128'(0));
        chk("held_result", 128'(result), 128'(held_res));
        chk("held_error", 128'(error), 128'(held_err));
      end
      if (!m_act && !fin && start) begin
        model(base, exp_in, prime, m_res, m_err, m_lat);
        m_act = 1'b1;
        m_k   = 0;
      end
    end
  end

  task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] p,
                     input logic [W-1:0] xr, input logic xe, input int xlat, input bit inject);
    int dk;
    @(posedge clk); #1;
    base = b; exp_in = e; prime = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dk = 0;
    while (!done && dk < 2000) begin
      start = inject && (dk == 20);
      if (start) exp_in = EW'(3);
      @(posedge clk); #1;
      dk++;
    end
    start = 1'b0;
    if (dk >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no done within 2000 cycles");
    end else begin
      chk("latency", 128'(dk), 128'(xlat));
      chk("lit_result", 128'(result), 128'(xr));
      chk("lit_error", 128'(error), 128'(xe));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_result", 128'(result), 128'(0));
    chk("rst_error", 128'(error), 128'(0));
    rst_n = 1'b1;

    run(W'(4), EW'(13), W'(497), W'(445), 1'b0, 405 + Red, 1'b0);
    run(W'(2), EW'(10), W'(1000), W'(24), 1'b0, 405 + Red, 1'b1);
    run(W'(7), EW'(0), W'(11), W'(1), 1'b0, 1 + Red, 1'b0);
    run(W'(0), EW'(0), W'(1), W'(0), 1'b0, 1 + Red, 1'b0);
`ifdef MODEXP_BASE_REDUCE_EN
    run(W'(501), EW'(13), W'(497), W'(445), 1'b0, 505, 1'b0);
`else
    run(W'(501), EW'(13), W'(497), W'(0), 1'b1, 1, 1'b0);
`endif
    run(W'(5), EW'(3), W'(0), W'(0), 1'b1, 1, 1'b0);
    run(W'(4), EW'(13), W'(497), W'(445), 1'b0, 405 + Red, 1'b0);

    // Abort a run mid-way with reset, then repeat it cleanly.
    @(posedge clk); #1;
    base = W'(4); exp_in = EW'(13); prime = W'(497); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_result", 128'(result), 128'(0));
    chk("abort_error", 128'(error), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(W'(4), EW'(13), W'(497), W'(445), 1'b0, 405 + Red, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
